// File: rtl/schmitt_trigger_ctrl.sv
// Clocked hysteresis controller: an inverting Schmitt trigger over an unsigned sample stream,
// with runtime thresholds/dwell loaded over a valid/ready config port.
module schmitt_trigger_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_maxi,
  input  logic [WIDTH-1:0]   cfg_mini,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic               cfg_err,
  output logic               configured,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_val,
  output logic               out_val,
  output logic               out_valid,
  output logic               rise,
  output logic               fall
);

  localparam int CW = DWELL_W + 1;

  typedef enum logic [2:0] {
    UNCFG   = 3'd0,
    OUT_LO  = 3'd1,
    PEND_HI = 3'd2,
    OUT_HI  = 3'd3,
    PEND_LO = 3'd4
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   maxi_q;
  logic [WIDTH-1:0]   mini_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt_q;
  logic               out_val_q;
  logic               out_valid_q;
  logic               rise_q;
  logic               fall_q;
  logic               cfg_err_q;
  logic               configured_q;

  logic [CW-1:0]      cnt_d;
  logic [CW-1:0]      need_s;
  logic               cfg_ok_s;
  logic               qual_lo_s;
  logic               qual_hi_s;
  logic               sample_acc_s;
  logic               reach_s;

  assign cfg_ready    = 1'b1;
  assign in_ready     = configured_q && !cfg_valid;
  assign sample_acc_s = in_valid && in_ready;
  assign cfg_ok_s     = (cfg_mini < cfg_maxi);
  assign qual_lo_s    = (in_val <= mini_q);
  assign qual_hi_s    = (in_val > maxi_q);
  assign cnt_d        = {1'b0, cnt_q} + {{DWELL_W{1'b0}}, 1'b1};
  // A dwell of zero behaves exactly like a dwell of one.
  assign need_s       = (dwell_q == {DWELL_W{1'b0}}) ? {{DWELL_W{1'b0}}, 1'b1} : {1'b0, dwell_q};
  assign reach_s      = (cnt_d >= need_s);

  assign out_val    = out_val_q;
  assign out_valid  = out_valid_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign cfg_err    = cfg_err_q;
  assign configured = configured_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNCFG;
      maxi_q       <= {WIDTH{1'b0}};
      mini_q       <= {WIDTH{1'b0}};
      dwell_q      <= {DWELL_W{1'b0}};
      cnt_q        <= {DWELL_W{1'b0}};
      out_val_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      configured_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      if (cfg_valid) begin
        // Reconfig wins over samples; out_val survives a valid reload.
        if (cfg_ok_s) begin
          maxi_q       <= cfg_maxi;
          mini_q       <= cfg_mini;
          dwell_q      <= cfg_dwell;
          cnt_q        <= {DWELL_W{1'b0}};
          configured_q <= 1'b1;
          state_q      <= out_val_q ? OUT_HI : OUT_LO;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end else if (sample_acc_s) begin
        out_valid_q <= 1'b1;
        case (state_q)
          OUT_LO, PEND_HI: begin
            if (qual_lo_s) begin
              if (reach_s) begin
                out_val_q <= 1'b1;
                rise_q    <= 1'b1;
                cnt_q     <= {DWELL_W{1'b0}};
                state_q   <= OUT_HI;
              end else begin
                cnt_q   <= cnt_d[DWELL_W-1:0];
                state_q <= PEND_HI;
              end
            end else begin
              cnt_q   <= {DWELL_W{1'b0}};
              state_q <= OUT_LO;
            end
          end
          OUT_HI, PEND_LO: begin
            if (qual_hi_s) begin
              if (reach_s) begin
                out_val_q <= 1'b0;
                fall_q    <= 1'b1;
                cnt_q     <= {DWELL_W{1'b0}};
                state_q   <= OUT_LO;
              end else begin
                cnt_q   <= cnt_d[DWELL_W-1:0];
                state_q <= PEND_LO;
              end
            end else begin
              cnt_q   <= {DWELL_W{1'b0}};
              state_q <= OUT_HI;
            end
          end
          UNCFG: begin
            state_q <= UNCFG;
          end
          default: begin
            state_q <= UNCFG;
            cnt_q   <= {DWELL_W{1'b0}};
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

endmodule

// File: tb/tb_schmitt_trigger_ctrl.sv
// Directed + randomized bench for schmitt_trigger_ctrl against a behavioural hysteresis model.
module tb_schmitt_trigger_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_maxi;
  logic [7:0] cfg_mini;
  logic [3:0] cfg_dwell;
  logic       cfg_err;
  logic       configured;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_val;
  logic       out_val;
  logic       out_valid;
  logic       rise;
  logic       fall;

  int checks = 0;
  int errors = 0;

  // Model: the trigger level, a run length of consecutive qualifying samples, and the config.
  int m_cfg, m_out, m_run, m_max, m_min, m_dwell;
  int e_ov, e_rise, e_fall, e_err;

  schmitt_trigger_ctrl #(.WIDTH(8), .DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_maxi(cfg_maxi), .cfg_mini(cfg_mini), .cfg_dwell(cfg_dwell),
    .cfg_err(cfg_err), .configured(configured),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val),
    .out_val(out_val), .out_valid(out_valid), .rise(rise), .fall(fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg = 0; m_out = 0; m_run = 0; m_max = 0; m_min = 0; m_dwell = 0;
  endtask

  task automatic check_outputs();
    chk("out_val", int'(out_val), m_out);
    chk("out_valid", int'(out_valid), e_ov);
    chk("rise", int'(rise), e_rise);
    chk("fall", int'(fall), e_fall);
    chk("cfg_err", int'(cfg_err), e_err);
    chk("configured", int'(configured), m_cfg);
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1 with outputs checked.
  task automatic step(input logic cv, input logic [7:0] mx, input logic [7:0] mn,
                      input logic [3:0] dw, input logic iv, input logic [7:0] v);
    int need;
    bit qual;
    cfg_valid = cv; cfg_maxi = mx; cfg_mini = mn; cfg_dwell = dw;
    in_valid = iv; in_val = v;
    #1;
    chk("cfg_ready", int'(cfg_ready), 1);
    chk("in_ready", int'(in_ready), (m_cfg != 0 && !cv) ? 1 : 0);
    e_ov = 0; e_rise = 0; e_fall = 0; e_err = 0;
    if (cv) begin
      if (int'(mn) < int'(mx)) begin
        m_cfg = 1; m_max = int'(mx); m_min = int'(mn); m_dwell = int'(dw); m_run = 0;
      end else begin
        e_err = 1;
      end
    end else if (iv && m_cfg != 0) begin
      e_ov = 1;
      qual = (m_out != 0) ? (int'(v) > m_max) : (int'(v) <= m_min);
      need = (m_dwell == 0) ? 1 : m_dwell;
      if (qual) begin
        m_run++;
        if (m_run >= need) begin
          m_out = 1 - m_out;
          if (m_out != 0) e_rise = 1; else e_fall = 1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic cfg(input logic [7:0] mx, input logic [7:0] mn, input logic [3:0] dw);
    step(1'b1, mx, mn, dw, 1'b0, 8'd0);
  endtask

  task automatic smp(input logic [7:0] v);
    step(1'b0, 8'd0, 8'd0, 4'd0, 1'b1, v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    e_ov = 0; e_rise = 0; e_fall = 0; e_err = 0;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] rv;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_maxi = 8'd0; cfg_mini = 8'd0; cfg_dwell = 4'd0;
    in_valid = 1'b0; in_val = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Unconfigured: samples are refused and nothing moves.
    smp(8'd100);
    smp(8'd10);
    chk("uncfg_out_val", int'(out_val), 0);

    // dwell=0 basic hysteresis.
    cfg(8'd200, 8'd50, 4'd0);
    smp(8'd100); chk("p1_s100", int'(out_val), 0);
    smp(8'd40);  chk("p1_s40_rise", int'(rise), 1);
    smp(8'd120); chk("p1_s120", int'(out_val), 1);
    smp(8'd210); chk("p1_s210_fall", int'(fall), 1);

    // dwell=3; mid-band sample restarts the count.
    cfg(8'd200, 8'd50, 4'd3);
    smp(8'd40); smp(8'd40); smp(8'd100); smp(8'd40); smp(8'd40);
    chk("dw_no_flip", int'(out_val), 0);
    smp(8'd40); chk("dw_rise", int'(rise), 1);

    // Reset mid-pending discards the partial count.
    smp(8'd210); smp(8'd210);
    do_reset();
    cfg(8'd200, 8'd50, 4'd2);
    smp(8'd40); chk("rst_cnt_gone", int'(out_val), 0);

    // Invalid config from fresh reset, then a valid one.
    do_reset();
    cfg(8'd200, 8'd200, 4'd0);
    chk("bad_cfg_err", int'(cfg_err), 1);
    chk("bad_cfg_uncfg", int'(configured), 0);
    step(1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 8'd0);
    cfg(8'd20, 8'd10, 4'd0);
    chk("good_cfg", int'(configured), 1);
    smp(8'd5); chk("cfg2_rise", int'(out_val), 1);

    // Reconfig colliding with a sample: sample refused, new thresholds take over.
    step(1'b1, 8'd100, 8'd50, 4'd0, 1'b1, 8'd30);
    chk("collide_hold", int'(out_val), 1);
    smp(8'd60);  chk("new_thr_nofall", int'(out_val), 1);
    smp(8'd101); chk("new_thr_fall", int'(fall), 1);

    // Threshold boundaries.
    cfg(8'd200, 8'd50, 4'd1);
    smp(8'd50);  chk("bnd_50_rise", int'(rise), 1);
    smp(8'd200); chk("bnd_200_hold", int'(out_val), 1);
    smp(8'd201); chk("bnd_201_fall", int'(fall), 1);
    cfg(8'd255, 8'd0, 4'd0);
    smp(8'd0);   chk("ext_0_rise", int'(rise), 1);
    smp(8'd255); chk("ext_255_hold", int'(out_val), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: rv = 8'(m_min);
        1: rv = 8'(m_max);
        2: rv = 8'(m_max + 1);
        default: rv = 8'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           4'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
